i2c_master_tx: RTL and testbench

//  I2C master (write-only) that sends one 32-bit word to the slave_top I2C slave controller.
//  It is the transmitting end of the same link as the slave.

---
 rtl/i2c_master_tx.sv | 253 +++++++++++++++++++++++++
 tb/tb_i2c_master_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_tx.sv
// i2c_master_tx: write-only I2C master that sends one 32-bit word to a single slave.
// Frame: START, {addr, W=0}, ACK, four data bytes (MSB byte and MSB bit first),
// each followed by an ACK slot, then STOP. A NACK in any slot ends the frame with STOP.
//
// Ports
//   CLK        system clock, rising edge
//   RST        asynchronous active-low reset
//   start      transfer request, only looked at in IDLE
//   addr       7-bit slave address, latched on accept
//   data_in    32-bit word, latched on accept
//   busy       high from the accepted start until done
//   done       one-cycle pulse at the end of the frame
//   ack_err    1 = a NACK ended the frame; holds until the next accepted start
//   i2c_sda    open-drain data line (driven 0 or released)
//   i2c_scl    open-drain clock line (driven 0 or released)
//   state_out  current state code
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | 0: lines released, waiting for start
// START | 1: SDA falls while SCL high, then SCL pulled low
// ADDR  | 2: shifting out {addr, 1'b0}
// ACK   | 3: SDA released, slave response sampled in q2
// DATA  | 4: shifting out the current data byte
// STOP  | 5: SDA rises while SCL high, then frame ends

module i2c_master_tx #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int I2C_FREQ_HZ = 100_000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [6:0]  addr,
    input  logic [31:0] data_in,
    output logic        busy,
    output logic        done,
    output logic        ack_err,
    inout  wire         i2c_sda,
    inout  wire         i2c_scl,
    output logic [2:0]  state_out
);

    localparam int QDIV = CLK_FREQ_HZ / (4 * I2C_FREQ_HZ);
    localparam int QW   = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [QW-1:0] QMAX = QW'(QDIV - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_ACK   = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;

    logic [2:0]    state_q,     state_d;
    logic [QW-1:0] qcnt_q,      qcnt_d;
    logic [1:0]    quarter_q,   quarter_d;
    logic [2:0]    bit_q,       bit_d;
    logic [1:0]    byte_q,      byte_d;
    logic [6:0]    addr_q,      addr_d;
    logic [31:0]   data_q,      data_d;
    logic          busy_q,      busy_d;
    logic          done_q,      done_d;
    logic          ack_err_q,   ack_err_d;
    logic          nack_q,      nack_d;
    logic          from_addr_q, from_addr_d;

    logic       scl_in;
    logic       sda_in;
    logic       hold;
    logic       tick;
    logic       last_q;
    logic [7:0] addr_byte;
    logic [7:0] data_byte;
    logic       tx_bit;
    logic       scl_low;
    logic       sda_low;

    // Raw line reads: a synchroniser would make the master see its own q0 low
    // for extra cycles after releasing SCL and stretch every bit.
    assign scl_in = i2c_scl;
    assign sda_in = i2c_sda;

    // A slave holding SCL low while we have released it freezes the quarter timer.
    assign hold   = (quarter_q == 2'd1 || quarter_q == 2'd2) && !scl_in;
    assign tick   = busy_q && !hold && (qcnt_q == QMAX);
    assign last_q = tick && (quarter_q == 2'd3);

    assign addr_byte = {addr_q, 1'b0};

    always_comb begin
        case (byte_q)
            2'd0:    data_byte = data_q[31:24];
            2'd1:    data_byte = data_q[23:16];
            2'd2:    data_byte = data_q[15:8];
            default: data_byte = data_q[7:0];
        endcase
    end

    assign tx_bit = (state_q == S_ADDR) ? addr_byte[bit_q] : data_byte[bit_q];

    always_comb begin
        state_d     = state_q;
        quarter_d   = quarter_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        addr_d      = addr_q;
        data_d      = data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ack_err_d   = ack_err_q;
        nack_d      = nack_q;
        from_addr_d = from_addr_q;

        if (!busy_q)
            qcnt_d = '0;
        else if (hold)
            qcnt_d = qcnt_q;
        else if (qcnt_q == QMAX)
            qcnt_d = '0;
        else
            qcnt_d = qcnt_q + 1'b1;

        if (tick)
            quarter_d = quarter_q + 2'd1;

        case (state_q)
            S_IDLE: begin
                // done_q blocks a start seen in the same cycle as the done pulse
                if (start && !done_q) begin
                    addr_d    = addr;
                    data_d    = data_in;
                    busy_d    = 1'b1;
                    ack_err_d = 1'b0;
                    nack_d    = 1'b0;
                    quarter_d = 2'd0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                bit_d       = 3'd7;
                byte_d      = 2'd0;
                from_addr_d = 1'b1;
                if (last_q)
                    state_d = S_ADDR;
            end
            S_ADDR, S_DATA: begin
                if (last_q) begin
                    bit_d = bit_q - 3'd1;
                    if (bit_q == 3'd0)
                        state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (tick && quarter_q == 2'd2) begin
                    nack_d = sda_in;
                    if (sda_in)
                        ack_err_d = 1'b1;
                end
                if (last_q) begin
                    from_addr_d = 1'b0;
                    if (nack_q)
                        state_d = S_STOP;
                    else if (from_addr_q)
                        state_d = S_DATA;
                    else if (byte_q == 2'd3)
                        state_d = S_STOP;
                    else begin
                        byte_d  = byte_q + 2'd1;
                        state_d = S_DATA;
                    end
                end
            end
            S_STOP: begin
                if (last_q) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            qcnt_q      <= '0;
            quarter_q   <= 2'd0;
            bit_q       <= 3'd0;
            byte_q      <= 2'd0;
            addr_q      <= 7'd0;
            data_q      <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ack_err_q   <= 1'b0;
            nack_q      <= 1'b0;
            from_addr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            qcnt_q      <= qcnt_d;
            quarter_q   <= quarter_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ack_err_q   <= ack_err_d;
            nack_q      <= nack_d;
            from_addr_q <= from_addr_d;
        end
    end

    // Line drive is decoded from registered state only, so reset releases both
    // lines immediately.
    always_comb begin
        scl_low = 1'b0;
        sda_low = 1'b0;
        case (state_q)
            S_START: begin
                sda_low = (quarter_q >= 2'd2);
                scl_low = (quarter_q == 2'd3);
            end
            S_ADDR, S_DATA: begin
                scl_low = (quarter_q == 2'd0 || quarter_q == 2'd3);
                sda_low = !tx_bit;
            end
            S_ACK: begin
                scl_low = (quarter_q == 2'd0 || quarter_q == 2'd3);
            end
            S_STOP: begin
                scl_low = (quarter_q == 2'd0);
                sda_low = (quarter_q <= 2'd1);
            end
            default: begin
                scl_low = 1'b0;
                sda_low = 1'b0;
            end
        endcase
    end

    assign i2c_sda   = sda_low ? 1'b0 : 1'bz;
    assign i2c_scl   = scl_low ? 1'b0 : 1'bz;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ack_err   = ack_err_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_i2c_master_tx.sv
module tb_i2c_master_tx;

    localparam int QDIV = 10;
    localparam int E1   = 93 * QDIV;   // q1 of phase 23 (data byte 1, bit 3)

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  addr = 7'd0;
    logic [31:0] data_in = 32'd0;
    logic        busy, done, ack_err;
    logic [2:0]  state_out;
    wire         sda_bus, scl_bus;
    logic        tb_sda_low = 1'b0;
    logic        tb_scl_low = 1'b0;

    pullup (sda_bus);
    pullup (scl_bus);
    assign sda_bus = tb_sda_low ? 1'b0 : 1'bz;
    assign scl_bus = tb_scl_low ? 1'b0 : 1'bz;

    int checks = 0;
    int errors = 0;

    logic [7:0] mon_bytes[$];
    int         mon_starts, mon_stops, mon_bitn;
    logic [7:0] mon_sh;
    logic       prev_scl, prev_sda;

    i2c_master_tx #(.CLK_FREQ_HZ(4_000_000), .I2C_FREQ_HZ(100_000)) dut (
        .CLK(clk), .RST(rst_n), .start(start), .addr(addr), .data_in(data_in),
        .busy(busy), .done(done), .ack_err(ack_err),
        .i2c_sda(sda_bus), .i2c_scl(scl_bus), .state_out(state_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int j, input logic [6:0] a, input logic [31:0] d);
        if (j == 0) return {a, 1'b0};
        return d[8*(4-j) +: 8];
    endfunction

    // Phase list: 0 START, then 9 phases per byte (8 bits + ACK), STOP after the
    // NACKed slot or after the last ACK. nk = ACK slot the slave NACKs (5 = none).
    function automatic int stop_phase(input int nk);
        return (nk < 5) ? 10 + 9*nk : 46;
    endfunction

    function automatic void model(input int qi, input logic [6:0] a, input logic [31:0] d,
                                  input int nk, output logic scl, output logic sda,
                                  output logic [2:0] st, output logic slv);
        int p, qq, sp, r, j, pos;
        logic [7:0] b;
        p = qi / 4; qq = qi % 4; sp = stop_phase(nk);
        scl = 1'b1; sda = 1'b1; st = 3'd0; slv = 1'b0;
        if (p > sp) return;
        if (p == 0) begin
            st = 3'd1; sda = (qq < 2); scl = (qq != 3);
        end else if (p == sp) begin
            st = 3'd5; scl = (qq != 0); sda = (qq >= 2);
        end else begin
            r = p - 1; j = r / 9; pos = r % 9;
            scl = (qq == 1 || qq == 2);
            if (pos == 8) begin
                st = 3'd3; slv = (j != nk); sda = !slv;
            end else begin
                st = (j == 0) ? 3'd2 : 3'd4;
                b = exp_byte(j, a, d);
                sda = b[7-pos];
            end
        end
    endfunction

    task automatic mon_step(input logic scl, input logic sda);
        if (prev_scl && scl && prev_sda && !sda) begin
            mon_starts++; mon_bitn = 0;
        end else if (prev_scl && scl && !prev_sda && sda) begin
            mon_stops++;
        end else if (!prev_scl && scl) begin
            if (mon_bitn == 8) mon_bitn = 0;
            else begin
                mon_sh = {mon_sh[6:0], sda};
                mon_bitn++;
                if (mon_bitn == 8) mon_bytes.push_back(mon_sh);
            end
        end
        prev_scl = scl; prev_sda = sda;
    endtask

    // Called right after the accept edge (+#1). c counts clock edges after accept.
    task automatic track(input logic [6:0] a, input logic [31:0] d, input int nk,
                         input int s_len, input int poke_c, input int rst_c, input bit chain,
                         input logic [6:0] na, input logic [31:0] nd, input int lit_done);
        int ltot, lim, m, done_c, nb;
        logic escl, esda, slv;
        logic [2:0] est;
        ltot = 4 * (stop_phase(nk) + 1) * QDIV + s_len;
        lim  = chain ? ltot + 1 : ltot + 3;
        done_c = -1;
        mon_bytes.delete();
        mon_starts = 0; mon_stops = 0; mon_bitn = 0; mon_sh = 8'd0;
        prev_scl = 1'b1; prev_sda = 1'b1;
        for (int c = 0; c <= lim; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (c == poke_c) begin start = 1'b1; data_in = 32'd0; end
            if (c == poke_c + 1) start = 1'b0;
            if (s_len > 0 && c == E1 - 2) tb_scl_low = 1'b1;
            if (s_len > 0 && c == E1 + s_len) tb_scl_low = 1'b0;
            if (c == rst_c) begin
                tb_sda_low = 1'b0; tb_scl_low = 1'b0;
                rst_n = 1'b0; #1;
                chk("rst_sda", sda_bus, 1); chk("rst_scl", scl_bus, 1);
                chk("rst_busy", busy, 0); chk("rst_state", state_out, 0);
                chk("rst_done", done, 0);
                @(posedge clk); #1; rst_n = 1'b1;
                @(posedge clk); #1;
                chk("post_rst_busy", busy, 0); chk("post_rst_state", state_out, 0);
                chk("post_rst_ackerr", ack_err, 0); chk("post_rst_sda", sda_bus, 1);
                return;
            end
            if (s_len > 0 && c > E1) m = (c <= E1 + s_len) ? E1 : c - s_len;
            else m = c;
            model(m / QDIV, a, d, nk, escl, esda, est, slv);
            tb_sda_low = slv;
            if (tb_scl_low) escl = 1'b0;
            #1;
            mon_step(scl_bus, sda_bus);
            chk("scl", scl_bus, escl);
            chk("sda", sda_bus, esda);
            chk("state", state_out, est);
            chk("busy", busy, (c < ltot));
            chk("done", done, (c == ltot));
            if (c == 0) chk("ack_err_clr", ack_err, 0);
            if (c >= ltot) chk("ack_err", ack_err, (nk < 5));
            if (done === 1'b1 && done_c < 0) done_c = c;
            if (chain && c == ltot - 1) begin
                start = 1'b1; addr = na; data_in = nd;
            end
        end
        chk("done_cycle", done_c, (lit_done >= 0) ? lit_done : ltot);
        nb = (nk < 5) ? nk + 1 : 5;
        chk("nbytes", mon_bytes.size(), nb);
        for (int j = 0; j < nb && j < mon_bytes.size(); j++)
            chk("bus_byte", mon_bytes[j], exp_byte(j, a, d));
        chk("starts", mon_starts, 1);
        chk("stops", mon_stops, 1);
    endtask

    task automatic launch(input logic [6:0] a, input logic [31:0] d, input int nk,
                          input int s_len, input int poke_c, input int rst_c, input int lit_done);
        @(posedge clk); #1;
        start = 1'b1; addr = a; data_in = d;
        @(posedge clk); #1;
        start = 1'b0;
        track(a, d, nk, s_len, poke_c, rst_c, 1'b0, 7'd0, 32'd0, lit_done);
    endtask

    task automatic chk_literal_bytes();
        logic [7:0] lit [5];
        lit[0] = 8'h84; lit[1] = 8'hDE; lit[2] = 8'hAD; lit[3] = 8'hBE; lit[4] = 8'hEF;
        for (int i = 0; i < 5; i++)
            chk("lit_byte", (i < mon_bytes.size()) ? {24'd0, mon_bytes[i]} : 32'hFFFF_FFFF,
                {24'd0, lit[i]});
    endtask

    initial begin
        logic [6:0]  ra;
        logic [31:0] rd;
        int          rnk, rpoke, rl;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0); chk("reset_done", done, 0);
        chk("reset_ackerr", ack_err, 0); chk("reset_state", state_out, 0);
        chk("reset_sda", sda_bus, 1); chk("reset_scl", scl_bus, 1);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // T1 full word, all ACKed
        launch(7'h42, 32'hDEADBEEF, 5, 0, -1, -1, 1880);
        chk_literal_bytes();
        // T2 address NACK
        launch(7'h42, 32'hDEADBEEF, 0, 0, -1, -1, 440);
        repeat (3) @(posedge clk);
        #1;
        chk("ack_err_hold", ack_err, 1);
        // T3 NACK on second data byte
        launch(7'h42, 32'hDEADBEEF, 2, 0, -1, -1, 1160);
        // T4 clock stretch of 37 cycles in byte 1 bit 3
        launch(7'h42, 32'hDEADBEEF, 5, 37, -1, -1, 1917);
        chk_literal_bytes();
        // T5 reset in the middle of DATA
        launch(7'h42, 32'hDEADBEEF, 5, 0, -1, 605, -1);
        // T6 start pulsed while busy with a zero word
        launch(7'h42, 32'hDEADBEEF, 5, 0, 700, -1, 1880);
        chk_literal_bytes();

        // start held through done: ignored in the done cycle, accepted one cycle later
        @(posedge clk); #1;
        start = 1'b1; addr = 7'h15; data_in = 32'h1234_5678;
        @(posedge clk); #1;
        track(7'h15, 32'h1234_5678, 5, 0, -1, -1, 1'b1, 7'h6B, 32'hA5C3_0F96, 1880);
        @(posedge clk); #1;
        start = 1'b0;
        track(7'h6B, 32'hA5C3_0F96, 3, 0, -1, -1, 1'b0, 7'd0, 32'd0, -1);

        // randomized frames
        for (int i = 0; i < 6; i++) begin
            ra  = 7'($urandom_range(0, 127));
            rd  = $urandom();
            rnk = $urandom_range(0, 5);
            rl  = 4 * (stop_phase(rnk) + 1) * QDIV;
            rpoke = ($urandom_range(0, 1) == 1) ? $urandom_range(10, rl - 20) : -1;
            launch(ra, rd, rnk, 0, rpoke, -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
